seg_scan_decoder: RTL and testbench
===================================

# seg_scan_decoder

Receive-side monitor for the multiplexed 4-digit seven-segment display bus. It samples the active-low anode-select and cathode lines driven by the display logic and recovers the hexadecimal value shown on each digit. It publishes a complete 4-digit frame once every digit has been seen stable. It sits next to the display driver in the top level and in self-checking benches, replacing manual inspection of printed anode and segment values.

## Interface

**Parameters**
- `SETTLE_CYCLES`, default 16: consecutive identical samples required before a digit is accepted. Legal range is 2..65535.

**Ports**
- `clk` in, 1: system clock. All inputs are synchronous to it.
- `reset` in, 1: synchronous, active-high reset.
- `an` in, 4: anode select, active-low. Bit i low selects digit i; digit 0 is the rightmost.
- `seg` in, 7: cathodes, active-low. Bit order is {g,f,e,d,c,b,a}, with `seg[0]` = a.
- `digits` out, 16: recovered nibbles. Digit i occupies `digits[4i+3:4i]`.
- `blank` out, 4: digit i was shown with all segments off.
- `err` out, 4: digit i showed an unrecognised pattern.
- `frame_valid` out, 1: single-cycle pulse when `digits`, `blank` and `err` have just been updated.
- `digit_strobe` out, 1: single-cycle pulse on each individual digit capture.

## Operation

- **Input stage:** `an` and `seg` are registered once into `an_q` and `seg_q`. `prev` holds the `{an_q, seg_q}` value from the previous cycle.
- **Valid anode:** `an_q` has exactly one zero bit (1110, 1101, 1011 or 0111). Any other value is "no digit".
- **FSM states:**
  - **IDLE:** `an_q` is not valid. Move to SETTLE when `an_q` becomes valid, with `cnt` set to 1.
  - **SETTLE:** if `{an_q, seg_q}` equals `prev`, increment `cnt`; otherwise set `cnt` to 1 and stay in SETTLE (or go to IDLE if `an_q` is invalid). When `cnt` reaches `SETTLE_CYCLES`, capture the digit and go to HELD.
  - **HELD:** the digit is already captured and is not recaptured. Any change in `{an_q, seg_q}` goes to SETTLE with `cnt` set to 1, or to IDLE if `an_q` is invalid.
- **Pattern decode** (active-high {g..a} form, i.e. `~seg_q`):
  - Digits: 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71 (all hex).
  - 00 means blank: nibble 0, blank=1.
  - Any other pattern means error: nibble 0, err=1.
- **Capture:** writes the nibble and flags into shadow slot i, sets `seen[i]`, and pulses `digit_strobe`. Recapturing an already-seen slot overwrites the slot and leaves `seen` unchanged.
- **Frame:** when a capture makes `seen` equal to 1111, all four shadow slots, including the one being written, are copied to `digits`/`blank`/`err`, `seen` clears to 0000, and `frame_valid` pulses.
- **Counter width:** `cnt` is `$clog2(SETTLE_CYCLES+1)` bits and saturates; it never wraps.

## Timing

- **Reset values:** `digits`=0000, `blank`=0000, `err`=0000, `frame_valid`=0, `digit_strobe`=0. Internally, `seen`=0000, `cnt`=0, state=IDLE.
- **Capture latency:** a value presented on `an`/`seg` from edge t and held stable produces `digit_strobe` high in the cycle after edge t+`SETTLE_CYCLES`+1.
- **Frame latency:** `frame_valid` rises in the same cycle as the `digit_strobe` of the completing digit. The outputs are valid in that cycle and hold until the next frame.
- **No back-to-back frames:** the next capture needs at least `SETTLE_CYCLES` cycles, so `frame_valid` never occurs on consecutive cycles.
- **Glitches:** a change of one cycle in either `an` or `seg` restarts settling, and the glitch value itself is never captured.
- **Reset mid-frame:** partial `seen` progress is discarded, and the outputs return to their reset values at the next edge.
- **Order independence:** a scan in descending, ascending or random order yields identical frames.

## Structure

- Package `seg_scan_pkg` holds:
  - the 16 segment-pattern localparams and the blank pattern;
  - the FSM state enum (IDLE, SETTLE, HELD);
  - the digit-slot record (nibble, blank, err).
- Sub-module `seg_pattern_decode`: a combinational 7-bit pattern to {nibble, blank, err} mapper, reused by the display-driver bench model.

## Test plan

All scenarios use `SETTLE_CYCLES`=4.

1. **Clean scan:** scan showing "1A0F" (`an` 0111→`seg` 1111001, 1011→0001000, 1101→1000000, 1110→0001110), each held 10 cycles. Expect one `frame_valid` with `digits`=16'h1A0F and `blank`=`err`=0000.
2. **Short holds:** a digit held only 3 cycles gives no `digit_strobe`. Held exactly 4 cycles, it gives `digit_strobe` 6 cycles after first presentation.
3. **Blank and error:** `seg`=1111111 on digit 2 and `seg`=1010101 on digit 0 give `blank`=0100, `err`=0001, and `digits[11:8]`=`digits[3:0]`=0.
4. **Invalid anodes:** `an`=1111 or 1100 for 20 cycles gives no captures and leaves the FSM in IDLE. `an`=0000 behaves the same.
5. **Glitch:** a one-cycle `seg` glitch on digit 3 after 3 stable cycles restarts settling, and the captured value is the post-glitch pattern.
6. **Reset recovery:** `reset` pulsed after 3 digits are captured clears `seen`. The next frame requires all 4 digits, and the outputs read 0 until then.

Source files
------------

// File: rtl/seg_scan_pkg.sv
// Shared types and constants for the seven-segment scan monitor.
// Segment patterns are active-high, in {g,f,e,d,c,b,a} order.
package seg_scan_pkg;

  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_A     = 7'h77;
  localparam logic [6:0] SEG_B     = 7'h7C;
  localparam logic [6:0] SEG_C     = 7'h39;
  localparam logic [6:0] SEG_D     = 7'h5E;
  localparam logic [6:0] SEG_E     = 7'h79;
  localparam logic [6:0] SEG_F     = 7'h71;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_HELD
  } state_e;

  typedef struct packed {
    logic [3:0] nibble;
    logic       blank;
    logic       err;
  } slot_t;

  function automatic logic anode_valid(input logic [3:0] an);
    return (an == 4'b1110) || (an == 4'b1101) || (an == 4'b1011) || (an == 4'b0111);
  endfunction

  function automatic logic [1:0] anode_index(input logic [3:0] an);
    logic [1:0] idx;
    case (an)
      4'b1101: idx = 2'd1;
      4'b1011: idx = 2'd2;
      4'b0111: idx = 2'd3;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/seg_pattern_decode.sv
// Maps an active-high segment pattern to a hex nibble, a blank flag
// or an error flag for patterns that are neither.
module seg_pattern_decode
  import seg_scan_pkg::*;
(
  input  logic [6:0] pattern,
  output slot_t      slot
);

  always_comb begin
    slot.nibble = 4'h0;
    slot.blank  = 1'b0;
    slot.err    = 1'b0;
    case (pattern)
      SEG_0:     slot.nibble = 4'h0;
      SEG_1:     slot.nibble = 4'h1;
      SEG_2:     slot.nibble = 4'h2;
      SEG_3:     slot.nibble = 4'h3;
      SEG_4:     slot.nibble = 4'h4;
      SEG_5:     slot.nibble = 4'h5;
      SEG_6:     slot.nibble = 4'h6;
      SEG_7:     slot.nibble = 4'h7;
      SEG_8:     slot.nibble = 4'h8;
      SEG_9:     slot.nibble = 4'h9;
      SEG_A:     slot.nibble = 4'hA;
      SEG_B:     slot.nibble = 4'hB;
      SEG_C:     slot.nibble = 4'hC;
      SEG_D:     slot.nibble = 4'hD;
      SEG_E:     slot.nibble = 4'hE;
      SEG_F:     slot.nibble = 4'hF;
      SEG_BLANK: slot.blank  = 1'b1;
      default:   slot.err    = 1'b1;
    endcase
  end

endmodule

// File: rtl/seg_scan_decoder.sv
// Monitors a multiplexed active-low 4-digit seven-segment bus and publishes
// a decoded frame once every digit has been observed stable.
module seg_scan_decoder
  import seg_scan_pkg::*;
#(
  parameter int SETTLE_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  an,
  input  logic [6:0]  seg,
  output logic [15:0] digits,
  output logic [3:0]  blank,
  output logic [3:0]  err,
  output logic        frame_valid,
  output logic        digit_strobe
);

  localparam int               CNT_W   = $clog2(SETTLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SETTLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [3:0]       an_q;
  logic [6:0]       seg_q;
  logic [10:0]      prev_q;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       seen_q, seen_d;
  slot_t [3:0]      shadow_q, shadow_d;
  logic [15:0]      digits_q, digits_d;
  logic [3:0]       blank_q, blank_d;
  logic [3:0]       err_q, err_d;
  logic             frame_q, frame_d;
  logic             strobe_q, strobe_d;

  logic [10:0]      cur;
  logic             same;
  logic             cur_valid;
  logic             capture;
  logic [1:0]       cap_idx;
  logic [6:0]       cap_pattern;
  slot_t            cap_slot;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v >= CNT_MAX) ? CNT_MAX : v + CNT_ONE;
  endfunction

  assign cur         = {an_q, seg_q};
  assign same        = (cur == prev_q);
  assign cur_valid   = anode_valid(an_q);
  // The settled value lives in prev_q, so a change arriving in the capture
  // cycle itself can never leak into the slot.
  assign capture     = (state_q == S_SETTLE) && (cnt_q >= CNT_MAX);
  assign cap_idx     = anode_index(prev_q[10:7]);
  assign cap_pattern = ~prev_q[6:0];

  seg_pattern_decode u_decode (
    .pattern (cap_pattern),
    .slot    (cap_slot)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (cur_valid) begin
          state_d = S_SETTLE;
          cnt_d   = CNT_ONE;
        end else begin
          cnt_d   = '0;
        end
      end
      S_SETTLE: begin
        if (same && capture) begin
          state_d = S_HELD;
        end else if (same) begin
          cnt_d   = sat_inc(cnt_q);
        end else if (cur_valid) begin
          cnt_d   = CNT_ONE;
        end else begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      end
      S_HELD: begin
        if (!same) begin
          state_d = cur_valid ? S_SETTLE : S_IDLE;
          cnt_d   = cur_valid ? CNT_ONE : '0;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    shadow_d = shadow_q;
    seen_d   = seen_q;
    digits_d = digits_q;
    blank_d  = blank_q;
    err_d    = err_q;
    frame_d  = 1'b0;
    strobe_d = capture;
    if (capture) begin
      shadow_d[cap_idx] = cap_slot;
      seen_d            = seen_q | (4'b0001 << cap_idx);
      // Completing slot is taken from shadow_d so the frame includes it.
      if (seen_d == 4'b1111) begin
        for (int i = 0; i < 4; i++) begin
          digits_d[4*i +: 4] = shadow_d[i].nibble;
          blank_d[i]         = shadow_d[i].blank;
          err_d[i]           = shadow_d[i].err;
        end
        seen_d  = '0;
        frame_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    an_q     <= an;
    seg_q    <= seg;
    prev_q   <= cur;
    shadow_q <= shadow_d;
    if (reset) begin
      seen_q   <= '0;
      digits_q <= '0;
      blank_q  <= '0;
      err_q    <= '0;
      frame_q  <= 1'b0;
      strobe_q <= 1'b0;
    end else begin
      seen_q   <= seen_d;
      digits_q <= digits_d;
      blank_q  <= blank_d;
      err_q    <= err_d;
      frame_q  <= frame_d;
      strobe_q <= strobe_d;
    end
  end

  assign digits       = digits_q;
  assign blank        = blank_q;
  assign err          = err_q;
  assign frame_valid  = frame_q;
  assign digit_strobe = strobe_q;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Bench for seg_scan_decoder: directed scenarios plus randomized scanning,
// compared every cycle against a run-length reference model.
module tb_seg_scan_decoder;

  localparam int S = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  an = 4'hF;
  logic [6:0]  seg = 7'h7F;
  logic [15:0] digits;
  logic [3:0]  blank;
  logic [3:0]  err;
  logic        frame_valid;
  logic        digit_strobe;

  seg_scan_decoder #(.SETTLE_CYCLES(S)) dut (
    .clk          (clk),
    .reset        (reset),
    .an           (an),
    .seg          (seg),
    .digits       (digits),
    .blank        (blank),
    .err          (err),
    .frame_valid  (frame_valid),
    .digit_strobe (digit_strobe)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] hex_pat(input int n);
    case (n)
      0: return 7'h3F;  1: return 7'h06;  2: return 7'h5B;  3: return 7'h4F;
      4: return 7'h66;  5: return 7'h6D;  6: return 7'h7D;  7: return 7'h07;
      8: return 7'h7F;  9: return 7'h6F;  10: return 7'h77; 11: return 7'h7C;
      12: return 7'h39; 13: return 7'h5E; 14: return 7'h79; default: return 7'h71;
    endcase
  endfunction

  // Reference model: a value sampled identically for S consecutive edges
  // (valid anode) is captured two edges after the S-th sample.
  logic [10:0] run_val = '0;
  int          run_len = 0;
  int          edge_n = 0;
  int          pend_due = -1;
  logic [10:0] pend_val = '0;
  logic [10:0] m_v;
  logic [3:0]  m_seen = '0;
  logic [3:0]  m_nib [4];
  logic        m_blk [4];
  logic        m_err [4];
  logic [15:0] exp_digits = '0;
  logic [3:0]  exp_blank = '0;
  logic [3:0]  exp_err = '0;
  logic        exp_strobe = 1'b0;
  logic        exp_frame = 1'b0;

  task automatic apply_capture(input logic [10:0] v);
    int idx;
    logic [6:0] pat;
    logic found;
    idx = 0;
    for (int i = 0; i < 4; i++) if (!v[7+i]) idx = i;
    pat = ~v[6:0];
    found = 1'b0;
    m_nib[idx] = 4'h0;
    m_blk[idx] = 1'b0;
    m_err[idx] = 1'b0;
    for (int n = 0; n < 16; n++)
      if (!found && hex_pat(n) == pat) begin
        found = 1'b1;
        m_nib[idx] = 4'(n);
      end
    if (!found) begin
      if (pat == 7'h00) m_blk[idx] = 1'b1;
      else m_err[idx] = 1'b1;
    end
    m_seen[idx] = 1'b1;
    exp_strobe = 1'b1;
    if (m_seen == 4'hF) begin
      for (int i = 0; i < 4; i++) begin
        exp_digits[4*i +: 4] = m_nib[i];
        exp_blank[i] = m_blk[i];
        exp_err[i] = m_err[i];
      end
      m_seen = '0;
      exp_frame = 1'b1;
    end
  endtask

  always @(posedge clk) begin
    m_v = {an, seg};
    edge_n++;
    exp_strobe = 1'b0;
    exp_frame = 1'b0;
    if (reset) begin
      pend_due = -1;
      m_seen = '0;
      exp_digits = '0;
      exp_blank = '0;
      exp_err = '0;
      run_val = m_v;
      run_len = 1;
    end else begin
      if (pend_due == edge_n) begin
        apply_capture(pend_val);
        pend_due = -1;
      end
      if (m_v == run_val) run_len++;
      else begin
        run_val = m_v;
        run_len = 1;
      end
      if (run_len == S && $countones(~m_v[10:7]) == 1) begin
        pend_due = edge_n + 2;
        pend_val = m_v;
      end
    end
  end

  logic check_en = 1'b0;
  int   strobe_cnt = 0;
  int   frame_cnt = 0;
  time  t_str = 0;

  always @(negedge clk) begin
    if (check_en) begin
      check_eq("digit_strobe", 32'(digit_strobe), 32'(exp_strobe));
      check_eq("frame_valid", 32'(frame_valid), 32'(exp_frame));
      check_eq("digits", 32'(digits), 32'(exp_digits));
      check_eq("blank", 32'(blank), 32'(exp_blank));
      check_eq("err", 32'(err), 32'(exp_err));
      if (digit_strobe) begin
        strobe_cnt++;
        t_str = $time;
      end
      if (frame_valid) frame_cnt++;
    end
  end

  task automatic show(input logic [3:0] a, input logic [6:0] s, input int n);
    an = a;
    seg = s;
    repeat (n) @(negedge clk);
  endtask

  task automatic show_hex(input logic [3:0] a, input int h, input int n);
    show(a, ~hex_pat(h), n);
  endtask

  task automatic do_reset();
    an = 4'hF;
    seg = 7'h7F;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0, f0;
    time t_pres;
    logic [3:0] ra;
    logic [6:0] rs;
    int sel;

    @(negedge clk);
    do_reset();
    check_en = 1'b1;
    #1;
    check_eq("reset_digits", 32'(digits), 32'h0);
    check_eq("reset_blank", 32'(blank), 32'h0);
    check_eq("reset_err", 32'(err), 32'h0);
    check_eq("reset_frame", 32'(frame_valid), 32'h0);
    check_eq("reset_strobe", 32'(digit_strobe), 32'h0);
    @(negedge clk);

    // Clean scan "1A0F"
    s0 = strobe_cnt; f0 = frame_cnt;
    show_hex(4'b0111, 1, 10);
    show_hex(4'b1011, 10, 10);
    show_hex(4'b1101, 0, 10);
    show_hex(4'b1110, 15, 10);
    show(4'hF, 7'h7F, 3);
    #1;
    check_eq("clean_frames", 32'(frame_cnt - f0), 32'd1);
    check_eq("clean_strobes", 32'(strobe_cnt - s0), 32'd4);
    check_eq("clean_digits", 32'(digits), 32'h1A0F);
    check_eq("clean_blank", 32'(blank), 32'h0);
    check_eq("clean_err", 32'(err), 32'h0);
    @(negedge clk);

    // Short holds
    do_reset();
    s0 = strobe_cnt;
    show_hex(4'b1110, 5, 3);
    show(4'hF, 7'h7F, 6);
    #1;
    check_eq("short3_strobes", 32'(strobe_cnt - s0), 32'd0);
    @(negedge clk);
    s0 = strobe_cnt;
    t_pres = $time;
    show_hex(4'b1110, 5, 4);
    show(4'hF, 7'h7F, 6);
    #1;
    check_eq("exact4_strobes", 32'(strobe_cnt - s0), 32'd1);
    check_eq("exact4_latency", 32'(t_str - t_pres), 32'd60);
    @(negedge clk);

    // Blank and error digits
    do_reset();
    show_hex(4'b0111, 5, 10);
    show(4'b1011, 7'b1111111, 10);
    show_hex(4'b1101, 7, 10);
    show(4'b1110, 7'b1010101, 10);
    show(4'hF, 7'h7F, 2);
    #1;
    check_eq("be_blank", 32'(blank), 32'b0100);
    check_eq("be_err", 32'(err), 32'b0001);
    check_eq("be_zero_nibbles", 32'(digits & 16'h0F0F), 32'h0);
    check_eq("be_digits", 32'(digits), 32'h5070);
    @(negedge clk);

    // Invalid anodes
    do_reset();
    s0 = strobe_cnt;
    show_hex(4'b1111, 3, 20);
    show_hex(4'b1100, 3, 20);
    show_hex(4'b0000, 3, 20);
    #1;
    check_eq("inv_strobes", 32'(strobe_cnt - s0), 32'd0);
    @(negedge clk);

    // One-cycle glitch on digit 3
    do_reset();
    f0 = frame_cnt;
    show_hex(4'b0111, 2, 3);
    show_hex(4'b0111, 8, 1);
    show_hex(4'b0111, 6, 10);
    show_hex(4'b1011, 1, 10);
    show_hex(4'b1101, 2, 10);
    show_hex(4'b1110, 3, 10);
    show(4'hF, 7'h7F, 2);
    #1;
    check_eq("glitch_frames", 32'(frame_cnt - f0), 32'd1);
    check_eq("glitch_digits", 32'(digits), 32'h6123);
    @(negedge clk);

    // Reset after three captures discards progress
    show_hex(4'b0111, 9, 10);
    show_hex(4'b1011, 14, 10);
    show_hex(4'b1101, 12, 10);
    show(4'hF, 7'h7F, 2);
    do_reset();
    #1;
    check_eq("rst_mid_digits", 32'(digits), 32'h0);
    @(negedge clk);
    f0 = frame_cnt;
    show_hex(4'b1110, 4, 10);
    show(4'hF, 7'h7F, 2);
    #1;
    check_eq("rst_partial_frames", 32'(frame_cnt - f0), 32'd0);
    check_eq("rst_partial_digits", 32'(digits), 32'h0);
    @(negedge clk);
    show_hex(4'b0111, 9, 10);
    show_hex(4'b1011, 14, 10);
    show_hex(4'b1101, 12, 10);
    show(4'hF, 7'h7F, 2);
    #1;
    check_eq("rst_recover_frames", 32'(frame_cnt - f0), 32'd1);
    check_eq("rst_recover_digits", 32'(digits), 32'h9EC4);
    @(negedge clk);

    // Randomized scanning in arbitrary order
    f0 = frame_cnt;
    for (int it = 0; it < 400; it++) begin
      if ($urandom_range(0, 9) < 8) ra = ~(4'b0001 << $urandom_range(0, 3));
      else ra = 4'($urandom);
      sel = int'($urandom_range(0, 17));
      if (sel < 16) rs = ~hex_pat(sel);
      else if (sel == 16) rs = 7'h7F;
      else rs = 7'($urandom);
      if ($urandom_range(0, 59) == 0) do_reset();
      show(ra, rs, int'($urandom_range(1, 8)));
    end
    show(4'hF, 7'h7F, 4);
    #1;
    check_eq("rand_frames_seen", 32'(frame_cnt > f0), 32'd1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
